// File: rtl/wb_timer.sv
// wb_timer: Wishbone B3 classic down-counting interval timer with prescaler, auto-reload and interrupt.
// Optional WB_TIMER_ERR_EN: offsets 5-7 are answered with wb_err_o instead of wb_ack_o.
module wb_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        int_o
);
  logic ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic en_q, en_d, ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
  logic [PRE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0] load_q, load_d, cnt_q, cnt_d;
  logic req, hit, wr, tick, expire;
  logic [2:0] sel;
  logic [31:0] rdata;
  logic unused_in;
  assign unused_in = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};
  always_comb begin
    sel = wb_adr_i[4:2];
    req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
`ifdef WB_TIMER_ERR_EN
    hit = req & (sel <= 3'd4);
    err_d = req & (sel > 3'd4);
`else
    hit = req;
    err_d = 1'b0;
`endif
    ack_d = hit;
    wr = hit & wb_we_i;
    tick = en_q & (pcnt_q == pre_q);
    expire = tick & (cnt_q == '0);
    rdata = sel == 3'd0 ? {29'b0, ie_q, ar_q, en_q} :
            sel == 3'd1 ? 32'(pre_q) :
            sel == 3'd2 ? 32'(load_q) :
            sel == 3'd3 ? 32'(cnt_q) :
            sel == 3'd4 ? {31'b0, exp_q} : 32'b0;
    dat_d = (hit & ~wb_we_i) ? rdata : 32'b0;
    // software write to CTRL wins over the one-shot hardware EN clear
    en_d = (wr && sel == 3'd0) ? wb_dat_i[0] : (expire & ~ar_q) ? 1'b0 : en_q;
    ar_d = (wr && sel == 3'd0) ? wb_dat_i[1] : ar_q;
    ie_d = (wr && sel == 3'd0) ? wb_dat_i[2] : ie_q;
    pre_d = (wr && sel == 3'd1) ? wb_dat_i[PRE_W-1:0] : pre_q;
    load_d = (wr && sel == 3'd2) ? wb_dat_i[CNT_W-1:0] : load_q;
    cnt_d = (wr && sel == 3'd3) ? wb_dat_i[CNT_W-1:0] :
            !tick ? cnt_q :
            (cnt_q != '0) ? cnt_q - CNT_W'(1) :
            ar_q ? load_q : cnt_q;
    exp_d = expire | (exp_q & ~(wr && sel == 3'd4 && wb_dat_i[0]));
    // a disabled timer holds pcnt at 0, so enabling always restarts the prescaler
    pcnt_d = (~en_q | tick | (wr && sel == 3'd1)) ? '0 : pcnt_q + PRE_W'(1);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      en_q <= 1'b0;
      ar_q <= 1'b0;
      ie_q <= 1'b0;
      exp_q <= 1'b0;
      pre_q <= '0;
      pcnt_q <= '0;
      load_q <= '0;
      cnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      en_q <= en_d;
      ar_q <= ar_d;
      ie_q <= ie_d;
      exp_q <= exp_d;
      pre_q <= pre_d;
      pcnt_q <= pcnt_d;
      load_q <= load_d;
      cnt_q <= cnt_d;
    end
  end
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign int_o = exp_q & ie_q;
endmodule
